sphere3_point_checker: RTL and testbench

Stream sink for the 4-D sphere point generators (e.g. `sphere3hopf_32bit`). It pulls points with `pop_enable`, captures each point on `in_valid`, and computes r² with a sequential square-accumulate. It flags points outside a unit-norm tolerance window and keeps a 16-bin orthant histogram. It serves as the in-fabric self-check for the generator, replacing floating-point bench checks.

---
 rtl/sphere3_check_pkg.sv | 25 ++
 rtl/sphere3_sq_acc.sv | 44 ++++
 rtl/sphere3_point_checker.sv | 144 ++++++++++++++
 tb/tb_sphere3_point_checker.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sphere3_check_pkg.sv
// Shared types, FSM states and r^2 window defaults for the sphere point checker.
package sphere3_check_pkg;

  typedef logic signed [31:0] coord_t;
  typedef logic        [31:0] r2_t;
  typedef logic        [3:0]  orthant_t;
  typedef logic        [65:0] acc_t;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StMac,
    StUpdate,
    StDone
  } state_e;

  localparam r2_t R2_LO_DEFAULT = 32'h3333_3333;
  localparam r2_t R2_HI_DEFAULT = 32'h4CCC_CCCC;

  // Q2.62 sum -> Q2.30, clamped once the sum reaches 4.0.
  function automatic r2_t acc_to_r2(input acc_t acc);
    return (acc[65:64] != 2'b00) ? 32'hFFFF_FFFF : acc[63:32];
  endfunction

endpackage

// File: rtl/sphere3_sq_acc.sv
// Sequential square-accumulate: one selected coordinate squared and summed per step.
module sphere3_sq_acc
  import sphere3_check_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       step,
  input  logic [1:0] idx,
  input  coord_t     x,
  input  coord_t     y,
  input  coord_t     z,
  input  coord_t     w,
  output acc_t       acc
);

  coord_t             sel;
  logic signed [63:0] sel_ext;
  logic        [63:0] sq;

  always_comb begin
    sel = x;
    unique case (idx)
      2'd0: sel = x;
      2'd1: sel = y;
      2'd2: sel = z;
      2'd3: sel = w;
    endcase
  end

  assign sel_ext = {{32{sel[31]}}, sel};
  assign sq      = sel_ext * sel_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (step) begin
      acc <= acc + {2'b00, sq};
    end
  end

endmodule

// File: rtl/sphere3_point_checker.sv
// Sphere point self-check sink: pulls points, checks r^2 window, counts results.
// Orthant histogram is built only when SPHERE3_CHECK_ORTHANT_EN is defined.
module sphere3_point_checker
  import sphere3_check_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter r2_t         R2_LO = R2_LO_DEFAULT,
  parameter r2_t         R2_HI = R2_HI_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_points,
  output logic             pop_enable,
  input  coord_t           in_x,
  input  coord_t           in_y,
  input  coord_t           in_z,
  input  coord_t           in_w,
  input  logic             in_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] point_count,
  output logic [CNT_W-1:0] bad_count,
  output r2_t              last_r2,
  input  orthant_t         rd_orthant,
  output logic [CNT_W-1:0] rd_count
);

  state_e           state;
  logic [1:0]       mac_idx;
  logic [CNT_W-1:0] target;
  coord_t           x_q, y_q, z_q, w_q;
  logic             pend;
  r2_t              r2_q, r2_now;
  logic             bad_q;
  orthant_t         orth_q;
  acc_t             acc;
  logic             start_ok, capture, mac_step;

  assign start_ok = start && (state == StIdle) && !busy;
  assign capture  = in_valid && (state == StReq);
  assign mac_step = (state == StMac);
  assign r2_now   = acc_to_r2(acc);

  sphere3_sq_acc u_sq_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (capture),
    .step  (mac_step),
    .idx   (mac_idx),
    .x     (x_q),
    .y     (y_q),
    .z     (z_q),
    .w     (w_q),
    .acc   (acc)
  );

  // Results of UPDATE are held in r2_q/bad_q/orth_q and committed one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= StIdle;
      mac_idx     <= '0;
      target      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      w_q         <= '0;
      pend        <= 1'b0;
      r2_q        <= '0;
      bad_q       <= 1'b0;
      orth_q      <= '0;
      pop_enable  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      point_count <= '0;
      bad_count   <= '0;
      last_r2     <= '0;
    end else begin
      pop_enable <= (state == StReq) && !in_valid;
      busy       <= (state != StIdle);
      done       <= (state == StDone);
      pend       <= 1'b0;
      if (pend) begin
        last_r2 <= r2_q;
        if (!(&point_count)) point_count <= point_count + CNT_W'(1);
        if (bad_q && !(&bad_count)) bad_count <= bad_count + CNT_W'(1);
      end
      unique case (state)
        StIdle: begin
          if (start_ok) begin
            target      <= num_points;
            point_count <= '0;
            bad_count   <= '0;
            state       <= (num_points == '0) ? StDone : StReq;
          end
        end
        StReq: begin
          if (in_valid) begin
            x_q     <= in_x;
            y_q     <= in_y;
            z_q     <= in_z;
            w_q     <= in_w;
            mac_idx <= '0;
            state   <= StMac;
          end
        end
        StMac: begin
          mac_idx <= mac_idx + 2'd1;
          if (mac_idx == 2'd3) state <= StUpdate;
        end
        StUpdate: begin
          r2_q   <= r2_now;
          bad_q  <= (r2_now < R2_LO) || (r2_now > R2_HI);
          orth_q <= {w_q[31], z_q[31], y_q[31], x_q[31]};
          pend   <= 1'b1;
          state  <= (({1'b0, point_count} + (CNT_W+1)'(1)) < {1'b0, target}) ? StReq : StDone;
        end
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

`ifdef SPHERE3_CHECK_ORTHANT_EN
  logic [CNT_W-1:0] hist [16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) hist[i] <= '0;
    end else if (start_ok) begin
      for (int i = 0; i < 16; i++) hist[i] <= '0;
    end else if (pend && !(&hist[orth_q])) begin
      hist[orth_q] <= hist[orth_q] + CNT_W'(1);
    end
  end

  assign rd_count = hist[rd_orthant];
`else
  logic unused_orth;
  assign unused_orth = ^{orth_q, rd_orthant};
  assign rd_count    = '0;
`endif

endmodule

// File: tb/tb_sphere3_point_checker.sv
// Bench for sphere3_point_checker: edge-scheduled reference model plus directed vectors.
module tb_sphere3_point_checker;

`ifdef SPHERE3_CHECK_ORTHANT_EN
  localparam bit HistEn = 1'b1;
`else
  localparam bit HistEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_points = '0;
  logic        pop_enable;
  logic [31:0] in_x = '0, in_y = '0, in_z = '0, in_w = '0;
  logic        in_valid = 1'b0;
  logic        busy, done;
  logic [15:0] point_count, bad_count, rd_count;
  logic [31:0] last_r2;
  logic [3:0]  rd_orthant = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sphere3_point_checker dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_points  (num_points),
    .pop_enable  (pop_enable),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_z        (in_z),
    .in_w        (in_w),
    .in_valid    (in_valid),
    .busy        (busy),
    .done        (done),
    .point_count (point_count),
    .bad_count   (bad_count),
    .last_r2     (last_r2),
    .rd_orthant  (rd_orthant),
    .rd_count    (rd_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (event times in counted edges) ----------------
  int          cyc, done_edge, commit_edge, busy_edge, req_from, captured, target;
  bit          running, waiting;
  logic        m_busy, m_pop, m_done;
  logic [15:0] m_pc, m_bad;
  logic [31:0] m_last, pend_r2;
  bit          pend_bad;
  logic [3:0]  pend_orth;
  logic [15:0] m_hist [16];

  function automatic logic [31:0] ref_r2(input logic [31:0] a, b, c, d);
    logic [65:0] sum;
    logic [31:0] v [4];
    sum = '0;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int i = 0; i < 4; i++) begin
      longint s;
      s = longint'($signed(v[i]));
      sum += 66'(s * s);
    end
    return (sum >= 66'h1_0000_0000_0000_0000) ? 32'hFFFF_FFFF : sum[63:32];
  endfunction

  task automatic model_reset();
    done_edge = -100; commit_edge = -100; busy_edge = -100; req_from = -100;
    captured = 0; target = 0; running = 0; waiting = 0;
    m_busy = 0; m_pop = 0; m_done = 0; m_pc = '0; m_bad = '0; m_last = '0;
    for (int i = 0; i < 16; i++) m_hist[i] = '0;
  endtask

  initial begin
    cyc = 0;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        bit accept;
        cyc++;
        accept = start && !running && !m_busy;
        if (cyc == commit_edge) begin
          if (m_pc != 16'hFFFF) m_pc++;
          if (pend_bad && m_bad != 16'hFFFF) m_bad++;
          m_last = pend_r2;
          if (m_hist[pend_orth] != 16'hFFFF) m_hist[pend_orth]++;
        end
        m_done = (cyc == done_edge);
        if (cyc == done_edge) running = 0;
        if (cyc == done_edge + 1) m_busy = 0;
        if (cyc == busy_edge) m_busy = 1;
        m_pop = 0;
        if (waiting && cyc >= req_from) begin
          if (in_valid) begin
            pend_r2     = ref_r2(in_x, in_y, in_z, in_w);
            pend_bad    = (pend_r2 < 32'h3333_3333) || (pend_r2 > 32'h4CCC_CCCC);
            pend_orth   = {in_w[31], in_z[31], in_y[31], in_x[31]};
            commit_edge = cyc + 6;
            captured++;
            if (captured < target) begin
              req_from = cyc + 6;
            end else begin
              waiting   = 0;
              done_edge = cyc + 6;
            end
          end else begin
            m_pop = 1;
          end
        end
        if (accept) begin
          m_pc = '0; m_bad = '0;
          for (int i = 0; i < 16; i++) m_hist[i] = '0;
          running = 1; target = int'(num_points); captured = 0; busy_edge = cyc + 1;
          if (num_points == 0) begin
            waiting = 0; done_edge = cyc + 1;
          end else begin
            waiting = 1; req_from = cyc + 1;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("busy", busy, m_busy);
        check("pop_enable", pop_enable, m_pop);
        check("done", done, m_done);
        check("point_count", point_count, m_pc);
        check("bad_count", bad_count, m_bad);
        check("last_r2", last_r2, m_last);
        check("rd_count", rd_count, HistEn ? m_hist[rd_orthant] : 16'h0);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
    rd_orthant = rd_orthant + 4'd1;
  endtask

  task automatic do_start(input logic [15:0] n);
    num_points = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_pop();
    for (int i = 0; i < 30 && !pop_enable; i++) tick();
    check("pop_wait", pop_enable, 1);
  endtask

  task automatic feed_point(input logic [31:0] a, b, c, d);
    wait_pop();
    in_x = a; in_y = b; in_z = c; in_w = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check("done_wait", done, 1);
  endtask

  task automatic check_bin(input logic [3:0] k, input logic [15:0] v);
    rd_orthant = k;
    #1;
    check("hist_bin", rd_count, HistEn ? v : 16'h0);
  endtask

  initial begin
    int n, dones;
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, dones;
    rst_n = 1'b0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_pop", pop_enable, 0);
    check("rst_done", done, 0);
    check("rst_pc", point_count, 0);
    rst_n = 1'b1;

    // Idle with in_valid toggling: nothing may start.
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      tick();
    end
    in_valid = 1'b0;
    check("idle_pop", pop_enable, 0);
    check("idle_last_r2", last_r2, 0);
    check("idle_bad", bad_count, 0);

    // One point, 0.5 on every axis -> r^2 = 1.0.
    do_start(16'd1);
    feed_point(32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000);
    wait_done(n);
    check("done_latency", n, 6);
    check("p1_last_r2", last_r2, 32'h4000_0000);
    check("p1_bad", bad_count, 0);
    check("p1_pc", point_count, 1);
    check_bin(4'd0, 16'd1);
    tick(); tick();

    // Two points: (-1,0,0,0) in window, origin out of window.
    do_start(16'd2);
    feed_point(32'h8000_0000, 32'h0, 32'h0, 32'h0);
    wait_pop();
    check("p2a_last_r2", last_r2, 32'h4000_0000);
    check("p2a_pc", point_count, 1);
    feed_point(32'h0, 32'h0, 32'h0, 32'h0);
    wait_done(n);
    check("p2b_last_r2", last_r2, 32'h0);
    check("p2b_bad", bad_count, 1);
    check("p2b_pc", point_count, 2);
    check_bin(4'd1, 16'd1);
    check_bin(4'd0, 16'd1);
    tick(); tick();

    // All -1: sum is exactly 4.0 and must saturate.
    do_start(16'd1);
    feed_point(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    wait_done(n);
    check("sat_last_r2", last_r2, 32'hFFFF_FFFF);
    check("sat_bad", bad_count, 1);
    check_bin(4'd15, 16'd1);
    tick(); tick();

    // in_valid held high throughout, stray start mid-run.
    in_x = 32'h4000_0000; in_y = 32'h4000_0000; in_z = 32'h4000_0000; in_w = 32'h4000_0000;
    in_valid = 1'b1;
    do_start(16'd2);
    tick(); tick();
    num_points = 16'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    num_points = 16'd2;
    wait_done(n);
    check("hold_pc", point_count, 2);
    check_bin(4'd0, 16'd2);
    in_valid = 1'b0;
    tick(); tick();
    check("hold_pc_after", point_count, 2);
    check("hold_busy_after", busy, 0);

    // Zero-point run: done in cycle S+1 only.
    do_start(16'd0);
    check("zero_done_s", done, 0);
    check("zero_pc", point_count, 0);
    tick();
    check("zero_done_s1", done, 1);
    check("zero_busy_s1", busy, 1);
    tick();
    check("zero_done_s2", done, 0);
    tick(); tick();

    // Reset during the second MAC cycle.
    do_start(16'd1);
    feed_point(32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000);
    tick();
    rst_n = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_pop", pop_enable, 0);
    check("mrst_pc", point_count, 0);
    check("mrst_bad", bad_count, 0);
    check("mrst_last_r2", last_r2, 0);
    check_bin(4'd0, 16'd0);
    tick(); tick();
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) dones++;
    end
    check("mrst_no_done", dones, 0);

    do_start(16'd1);
    feed_point(32'h4000_0000, 32'hC000_0000, 32'h4000_0000, 32'h4000_0000);
    wait_done(n);
    check("post_rst_latency", n, 6);
    check("post_rst_pc", point_count, 1);
    check("post_rst_last_r2", last_r2, 32'h4000_0000);
    check("post_rst_bad", bad_count, 0);
    check_bin(4'd2, 16'd1);
    tick(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
